// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Frame states, protocol byte values and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam int         PS2_FRAME_LEN = 11;
    localparam int         PS2_DATA_BITS = 8;

    // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Keyboard-data interface between the PS/2 receiver and the game FSM.
// The receiver drives the master side; the game FSM consumes the slave side.
interface ps2_key_receiver_if;

    logic [7:0] oKeyboard_data;
    logic       oKeyboard_data_en;
    logic       oError;

    modport master (
        output oKeyboard_data,
        output oKeyboard_data_en,
        output oError
    );

    modport slave (
        input oKeyboard_data,
        input oKeyboard_data_en,
        input oError
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line front end: synchronisers, clock glitch filter, 11-bit frame FSM
// and inactivity timeout. Reports each completed byte and any frame fault.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a PS/2 clock falling edge)
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit and parity, then back to IDLE
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_m,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       frame_timeout
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          dat_s;
    logic [FW-1:0] flt_cnt;
    logic          clk_flt;
    logic          clk_flt_q;
    logic          fall;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          frame_end;
    logic          frame_good;

    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    always_ff @(posedge clk or negedge reset_m) begin
        if (!reset_m) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    // The filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_m) begin
        if (!reset_m) begin
            flt_cnt   <= '0;
            clk_flt   <= 1'b1;
            clk_flt_q <= 1'b1;
        end else begin
            clk_flt_q <= clk_flt;
            if (clk_s == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                flt_cnt <= '0;
                clk_flt <= clk_s;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_flt_q & ~clk_flt;

    // Down-counter reloaded on every edge; reaching zero mid-frame is the timeout.
    always_ff @(posedge clk or negedge reset_m) begin
        if (!reset_m) begin
            to_cnt <= TO_LOAD;
        end else if (state == IDLE || fall || timeout) begin
            to_cnt <= TO_LOAD;
        end else begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    assign timeout = (state != IDLE) && !fall && (to_cnt == '0);

    always_ff @(posedge clk or negedge reset_m) begin
        if (!reset_m) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else if (timeout) begin
            state <= IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_s) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    shift   <= {dat_s, shift[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    par_bit <= dat_s;
                    state   <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign frame_end     = fall && (state == STOP);
    assign frame_good    = dat_s && parity_ok(shift, par_bit);
    assign rx_byte       = shift;
    assign byte_valid    = frame_end && frame_good;
    assign frame_timeout = timeout;
    assign frame_err     = (frame_end && !frame_good) || timeout;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: turns raw PS/2 frames into one code strobe per key
// press, suppressing break sequences and extended prefixes.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_m,
    input  logic                 iPS2_clk,
    input  logic                 iPS2_dat,
    ps2_key_receiver_if.master   kbd
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;
    logic       frame_timeout;

    logic       brk;
    logic [7:0] key_data;
    logic       key_en;
    logic       err_q;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk           (clk),
        .reset_m       (reset_m),
        .ps2_clk       (iPS2_clk),
        .ps2_dat       (iPS2_dat),
        .rx_byte       (rx_byte),
        .byte_valid    (byte_valid),
        .frame_err     (frame_err),
        .frame_timeout (frame_timeout)
    );

    // A corrupted frame may have been the release byte itself, so drop any
    // pending break; a timeout says nothing about the byte stream and keeps it.
    always_ff @(posedge clk or negedge reset_m) begin
        if (!reset_m) begin
            brk      <= 1'b0;
            key_data <= 8'h00;
            key_en   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            key_en <= 1'b0;
            err_q  <= frame_err;
            if (frame_err && !frame_timeout) begin
                brk <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == PS2_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_byte == PS2_EXT) begin
                    brk <= brk;
                end else if (brk) begin
                    brk <= 1'b0;
                end else begin
                    key_data <= rx_byte;
                    key_en   <= 1'b1;
                end
            end
        end
    end

    assign kbd.oKeyboard_data    = key_data;
    assign kbd.oKeyboard_data_en = key_en;
    assign kbd.oError            = err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Randomised self-checking bench for ps2_key_receiver against a byte-level
// decode model; directed frames pin the model with literal expectations.
module tb_ps2_key_receiver;

    localparam int FILT = 4;
    localparam int TOUT = 3000;
    localparam int LAT  = 2 + FILT + 1;

    logic clk = 1'b0;
    logic reset_m = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_key_receiver_if kbd ();

    ps2_key_receiver #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk      (clk),
        .reset_m  (reset_m),
        .iPS2_clk (ps2_clk),
        .iPS2_dat (ps2_dat),
        .kbd      (kbd.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stop_cyc = 0;
    int n_strobes = 0;
    int exp_err  = 0;
    logic [7:0] exp_q[$];
    logic       m_brk = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       prev_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-level decode rules: break prefix, extended prefix, release suppression.
    task automatic model_byte(input logic [7:0] b, input logic good);
        if (!good) begin
            exp_err++;
            m_brk = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_brk = m_brk;
        end else if (m_brk) begin
            m_brk = 1'b0;
        end else begin
            exp_q.push_back(b);
            m_data = b;
        end
    endtask

    always @(negedge clk) begin
        if (reset_m) begin
            if (kbd.oKeyboard_data_en) begin
                n_strobes++;
                check("strobe_width", {31'd0, prev_en}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {24'd0, kbd.oKeyboard_data}, 32'hFFFF_FFFF);
                end else begin
                    check("strobe_code", {24'd0, kbd.oKeyboard_data}, {24'd0, exp_q.pop_front()});
                    check("strobe_latency", cyc - stop_cyc, LAT);
                end
            end
            if (kbd.oError) begin
                if (exp_err == 0) check("unexpected_error", 32'd1, 32'd0);
                else exp_err--;
            end
            prev_en = kbd.oKeyboard_data_en;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits of a frame; glitch_bit >= 0 adds a short low pulse
    // on the PS/2 clock during that bit's high phase.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_v,
                              input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits = {stop_v, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_dat = bits[i];
            if (i == glitch_bit) begin
                wait_cyc(3);
                ps2_clk = 1'b0;
                wait_cyc(2);
                ps2_clk = 1'b1;
                wait_cyc(5);
            end else begin
                wait_cyc(10);
            end
            if (i == 10) begin
                stop_cyc = cyc;
                model_byte(b, stop_v && !bad_par);
            end
            ps2_clk = 1'b0;
            wait_cyc(20);
            ps2_clk = 1'b1;
            wait_cyc(10);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic frame_done(input string tag);
        wait_cyc(12);
        check({tag, "_pending_strobes"}, exp_q.size(), 0);
        check({tag, "_pending_errors"}, exp_err, 0);
        check({tag, "_held_data"}, {24'd0, kbd.oKeyboard_data}, {24'd0, m_data});
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        send_frame(b, 1'b0, 1'b1, 11, -1);
        frame_done(tag);
    endtask

    int s0;

    initial begin
        wait_cyc(5);
        check("reset_data", {24'd0, kbd.oKeyboard_data}, 32'h00);
        check("reset_en", {31'd0, kbd.oKeyboard_data_en}, 32'd0);
        check("reset_err", {31'd0, kbd.oError}, 32'd0);
        reset_m = 1'b1;
        wait_cyc(5);

        s0 = n_strobes;
        send(8'h1C, "first");
        check("first_code_lit", {24'd0, kbd.oKeyboard_data}, 32'h1C);
        check("first_count_lit", n_strobes - s0, 1);

        s0 = n_strobes;
        send(8'h1C, "seq_a");
        send(8'hF0, "seq_b");
        send(8'h1C, "seq_c");
        check("brk_seq_count_lit", n_strobes - s0, 1);
        send(8'h1D, "seq_d");
        check("after_brk_code_lit", {24'd0, kbd.oKeyboard_data}, 32'h1D);

        s0 = n_strobes;
        send(8'hE0, "ext_a");
        send(8'h75, "ext_b");
        check("ext_code_lit", {24'd0, kbd.oKeyboard_data}, 32'h75);
        send(8'hE0, "ext_c");
        send(8'hF0, "ext_d");
        send(8'h75, "ext_e");
        check("ext_count_lit", n_strobes - s0, 1);

        s0 = n_strobes;
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
        frame_done("bad_parity");
        check("bad_parity_keep_lit", {24'd0, kbd.oKeyboard_data}, 32'h75);
        send(8'h2B, "after_parity");
        check("after_parity_lit", {24'd0, kbd.oKeyboard_data}, 32'h2B);
        check("parity_count_lit", n_strobes - s0, 1);

        send_frame(8'h1C, 1'b0, 1'b1, 5, -1);
        exp_err++;
        wait_cyc(TOUT + 10);
        check("timeout_error_seen", exp_err, 0);
        send(8'h1C, "after_timeout");
        check("after_timeout_lit", {24'd0, kbd.oKeyboard_data}, 32'h1C);

        send(8'h2B, "pre_glitch");
        send_frame(8'h1C, 1'b0, 1'b1, 11, 4);
        frame_done("glitch");
        check("glitch_code_lit", {24'd0, kbd.oKeyboard_data}, 32'h1C);

        send_frame(8'h5A, 1'b0, 1'b1, 5, -1);
        @(negedge clk);
        reset_m = 1'b0;
        exp_q.delete();
        exp_err = 0;
        m_brk = 1'b0;
        m_data = 8'h00;
        wait_cyc(3);
        check("midreset_data", {24'd0, kbd.oKeyboard_data}, 32'h00);
        check("midreset_en", {31'd0, kbd.oKeyboard_data_en}, 32'd0);
        check("midreset_err", {31'd0, kbd.oError}, 32'd0);
        reset_m = 1'b1;
        wait_cyc(5);
        send(8'h33, "after_reset");
        check("after_reset_lit", {24'd0, kbd.oKeyboard_data}, 32'h33);

        for (int k = 0; k < 50; k++) begin
            logic [7:0] b;
            int sel;
            logic bp;
            logic sv;
            sel = $urandom_range(0, 9);
            if (sel < 2) b = 8'hF0;
            else if (sel == 2) b = 8'hE0;
            else b = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            sv = ($urandom_range(0, 14) != 0);
            send_frame(b, bp, sv, 11, ($urandom_range(0, 7) == 0) ? 6 : -1);
            frame_done("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Receives PS/2 keyboard frames from the board connector and delivers make codes on the keyboard-data interface consumed by the game FSM.
- Produces the signal pair that the game FSM consumes: an 8-bit code plus a one-cycle valid strobe.
- Filters and synchronises the PS/2 clock, deserialises 11-bit frames, and checks parity and stop bit.
- Suppresses break (key release) sequences and extended-prefix bytes, so each key press yields exactly one strobe.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered PS/2 clock changes.
- TIMEOUT_CYCLES, 50000: system cycles without a PS/2 clock falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset_m  input  1  asynchronous, active-low reset.
- iPS2_clk  input  1  raw PS/2 clock from the connector; asynchronous to clk.
- iPS2_dat  input  1  raw PS/2 data from the connector; asynchronous to clk.
- oKeyboard_data  output  8  last accepted make code; holds its value between strobes.
- oKeyboard_data_en  output  1  one-cycle strobe marking a new make code.
- oError  output  1  one-cycle strobe on a parity error, stop-bit error or timeout.

Behaviour:
- Reset values:
  - oKeyboard_data = 8'h00; oKeyboard_data_en = 0; oError = 0.
  - Filtered PS/2 clock = 1; synchroniser flops = 1.
  - Frame FSM in IDLE; break flag brk = 0.
- Synchronisation: iPS2_clk and iPS2_dat each pass through a 2-flop synchroniser.
- Clock filter: the filtered clock takes the synchronised value only after FILTER_LEN consecutive equal samples.
- Edge: a falling edge is the filtered clock going 1->0. It lasts one cycle. Synchronised data is sampled in that same cycle.
- Frame FSM, advanced only on a falling edge:
  - IDLE: data=0 -> DATA, bit count = 0. Data=1 -> stay in IDLE, no error.
  - DATA: shift the bit in, LSB first. After the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: frame is good if XOR(data[7:0], parity)=1 and stop=1. Either way -> IDLE.
- Frame errors:
  - Bad parity or stop=0: oError pulses, brk is cleared, and the byte is discarded.
- Timeout:
  - A cycle counter runs in every state except IDLE and is cleared on each falling edge.
  - When it reaches TIMEOUT_CYCLES-1: return to IDLE and pulse oError. brk is unchanged.
- Decode of each good byte:
  - 8'hF0: set brk; no strobe.
  - 8'hE0: ignored; the following byte is decoded normally.
  - Any other byte with brk=1: clear brk; no strobe (release suppressed).
  - Any other byte with brk=0: load oKeyboard_data, and assert oKeyboard_data_en in that same register update.
- Latency: oKeyboard_data_en is high in the cycle after the cycle containing the stop-bit falling edge. It is high for exactly one cycle.
- Simultaneous events: a timeout and an edge cannot both act, because an edge clears the counter with priority.
- Consecutive frames: back-to-back frames need no idle gap beyond the PS/2 line idle. A strobe never lasts more than one cycle.
- Reset mid-frame: asserting reset_m low aborts immediately and restores all reset values. The first frame after release is accepted normally.

Decomposition:
- Shared package (ps2_pkg):
  - frame-state enum: IDLE, DATA, PARITY, STOP;
  - constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0;
  - frame-length constant 11.
- Sub-module ps2_frame_rx:
  - contains the synchronisers, clock filter, frame FSM and timeout;
  - outputs byte, byte_valid and frame_err.
- Top ps2_key_receiver: holds the break/extended decode and the output registers.

Test Plan:
- Frame 0,0x1C LSB-first,parity 0,stop 1 -> oKeyboard_data=8'h1C, a single oKeyboard_data_en pulse one cycle after the stop edge, oError=0.
- Sequence 1C, F0, 1C -> exactly one strobe with 8'h1C. brk=0 at the end. A following 1D frame strobes 8'h1D.
- E0, 75 -> one strobe with 8'h75. E0, F0, 75 -> no strobe.
- 1C frame with parity bit flipped to 1 -> oError pulses once, no strobe, oKeyboard_data keeps its previous value. A following good 2B frame strobes 8'h2B.
- Stop TIMEOUT_CYCLES+10 cycles after 4 data bits -> oError pulses once, FSM in IDLE. A following full 1C frame strobes 8'h1C.
- Glitches and reset:
  - A 2-cycle low glitch on iPS2_clk (< FILTER_LEN) mid-frame causes no extra bit; the 0x1C frame is still decoded.
  - reset_m pulsed low mid-frame: all outputs are 0, and the next frame decodes correctly.
